bcd_seq_ctrl: RTL and testbench

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

---
 rtl/bcd_seq_ctrl.sv | 100 ++++++++++
 tb/tb_bcd_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Accepts one operand in IDLE, shifts for WIDTH cycles, presents the result for one DONE cycle.
module bcd_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIGIT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     Binary_code,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [DIGIT*4-1:0]   BCD_code
);

    localparam int BW = DIGIT * 4;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  shiftReg_q;
    logic [WIDTH-1:0]  shiftReg_d;
    logic [BW-1:0]     acc_q;
    logic [BW-1:0]     acc_d;
    logic [BW-1:0]     accAdj;
    logic [CW-1:0]     bitCnt_q;
    logic              inReady_q;
    logic              outValid_q;
    logic [BW-1:0]     bcd_q;

    // Digit correction before each shift keeps every nibble a legal decimal digit afterwards.
    always_comb begin
        accAdj = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                accAdj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end else begin
                accAdj[4*i +: 4] = acc_q[4*i +: 4];
            end
        end
        {acc_d, shiftReg_d} = {accAdj, shiftReg_q} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            acc_q      <= '0;
            bitCnt_q   <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            bcd_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shiftReg_q <= Binary_code;
                        acc_q      <= '0;
                        bitCnt_q   <= CW'(WIDTH);
                        inReady_q  <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q      <= acc_d;
                    shiftReg_q <= shiftReg_d;
                    bitCnt_q   <= bitCnt_q - 1'b1;
                    // The last shift result goes straight to the output register.
                    if (bitCnt_q == CW'(1)) begin
                        outValid_q <= 1'b1;
                        bcd_q      <= acc_d;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    outValid_q <= 1'b0;
                    bcd_q      <= '0;
                    inReady_q  <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    outValid_q <= 1'b0;
                    bcd_q      <= '0;
                    inReady_q  <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign BCD_code  = bcd_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Bench for bcd_seq_ctrl: four instances (WIDTH 4, 8, 12, 20) checked every cycle
// against a decimal-arithmetic model, plus directed vectors with literal results.
module tb_bcd_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        inValid [4];
    logic [19:0] binCode [4];
    logic        inReady [4];
    logic        outValid [4];
    logic [27:0] bcdOut [4];

    logic        rdy4, rdy8, rdy12, rdy20;
    logic        vld4, vld8, vld12, vld20;
    logic [7:0]  bcd4;
    logic [11:0] bcd8;
    logic [15:0] bcd12;
    logic [27:0] bcd20;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          inst;
        int          cyc;
        logic [27:0] bcd;
    } pulse_t;
    pulse_t pulses [$];
    int     pulseCnt [4] = '{0, 0, 0, 0};

    bit          busy [4] = '{0, 0, 0, 0};
    int          age [4]  = '{0, 0, 0, 0};
    logic [19:0] opnd [4];

    bcd_seq_ctrl #(.WIDTH(4), .DIGIT(2)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .Binary_code(binCode[0][3:0]),
        .in_ready(rdy4), .out_valid(vld4), .BCD_code(bcd4));
    bcd_seq_ctrl #(.WIDTH(8), .DIGIT(3)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .Binary_code(binCode[1][7:0]),
        .in_ready(rdy8), .out_valid(vld8), .BCD_code(bcd8));
    bcd_seq_ctrl #(.WIDTH(12), .DIGIT(4)) u12 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .Binary_code(binCode[2][11:0]),
        .in_ready(rdy12), .out_valid(vld12), .BCD_code(bcd12));
    bcd_seq_ctrl #(.WIDTH(20), .DIGIT(7)) u20 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[3]), .Binary_code(binCode[3]),
        .in_ready(rdy20), .out_valid(vld20), .BCD_code(bcd20));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Gather the four instances into arrays so tasks can address them by index.
    always_comb begin
        inReady[0]  = rdy4;   inReady[1]  = rdy8;   inReady[2]  = rdy12;  inReady[3]  = rdy20;
        outValid[0] = vld4;   outValid[1] = vld8;   outValid[2] = vld12;  outValid[3] = vld20;
        bcdOut[0]   = {20'd0, bcd4};
        bcdOut[1]   = {16'd0, bcd8};
        bcdOut[2]   = {12'd0, bcd12};
        bcdOut[3]   = bcd20;
    end

    function automatic int widthOf(input int idx);
        case (idx)
            0: return 4;
            1: return 8;
            2: return 12;
            default: return 20;
        endcase
    endfunction

    // Reference result by repeated division by ten.
    function automatic logic [27:0] toBcd(input logic [19:0] v);
        logic [27:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < 7; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an accepted operand appears on the output WIDTH edges later for one cycle,
    // and the instance becomes ready again on the edge after that.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                busy[i] <= 1'b0;
                age[i]  <= 0;
            end else if (busy[i]) begin
                if (age[i] == widthOf(i)) busy[i] <= 1'b0;
                else age[i] <= age[i] + 1;
            end else if (inValid[i]) begin
                busy[i] <= 1'b1;
                age[i]  <= 0;
                opnd[i] <= binCode[i] & ((20'h1 << widthOf(i)) - 20'h1);
            end
        end
    end

    // Every-cycle comparison against the model, plus a log of result pulses.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            logic        expValid;
            logic [27:0] expBcd;
            expValid = busy[i] && (age[i] == widthOf(i));
            expBcd   = expValid ? toBcd(opnd[i]) : 28'd0;
            check($sformatf("u%0d.in_ready", widthOf(i)), 28'(inReady[i]), 28'(!busy[i]));
            check($sformatf("u%0d.out_valid", widthOf(i)), 28'(outValid[i]), 28'(expValid));
            check($sformatf("u%0d.BCD_code", widthOf(i)), bcdOut[i], expBcd);
            if (outValid[i] === 1'b1) begin
                pulses.push_back('{inst: i, cyc: cyc, bcd: bcdOut[i]});
                pulseCnt[i]++;
            end
        end
    end

    task automatic applyStimulus(input int idx, input logic [19:0] val);
        @(negedge clk);
        inValid[idx] = 1'b1;
        binCode[idx] = val;
        @(negedge clk);
        inValid[idx] = 1'b0;
        binCode[idx] = ~val;
    endtask

    task automatic checkOutput(input int idx, input logic [27:0] expBcd, input int expWait,
                               input string name);
        int n;
        n = 0;
        while (outValid[idx] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            check({name, ".timeout"}, 28'(n), 28'(expWait));
        end else begin
            check({name, ".latency"}, 28'(n), 28'(expWait));
            check({name, ".value"}, bcdOut[idx], expBcd);
            @(negedge clk);
            check({name, ".validFall"}, 28'(outValid[idx]), 28'd0);
            check({name, ".zeroAfter"}, bcdOut[idx], 28'd0);
        end
    endtask

    task automatic waitReady(input int idx, input string name);
        int n;
        n = 0;
        while (inReady[idx] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check({name, ".readyTimeout"}, 28'(inReady[idx]), 28'd1);
    endtask

    initial begin
        int pc;
        int startIdx;
        int n;
        int found;
        int pcyc [3];
        logic [27:0] pbcd [3];
        logic [19:0] ops [3];

        for (int i = 0; i < 4; i++) begin
            inValid[i] = 1'b0;
            binCode[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset.u%0d.in_ready", widthOf(i)), 28'(inReady[i]), 28'd1);
            check($sformatf("reset.u%0d.out_valid", widthOf(i)), 28'(outValid[i]), 28'd0);
            check($sformatf("reset.u%0d.BCD_code", widthOf(i)), bcdOut[i], 28'd0);
        end
        rst_n = 1'b1;

        check("model.max20", toBcd(20'hFFFFF), 28'h1048575);
        check("model.4095", toBcd(20'd4095), 28'h0004095);

        // Small widths: boundary operands and ordinary values.
        applyStimulus(0, 20'd15);   checkOutput(0, 28'h15, 4, "w4.15");
        applyStimulus(0, 20'd0);    checkOutput(0, 28'h00, 4, "w4.0");
        applyStimulus(0, 20'd9);    checkOutput(0, 28'h09, 4, "w4.9");
        applyStimulus(0, 20'd10);   checkOutput(0, 28'h10, 4, "w4.10");
        applyStimulus(1, 20'd99);   checkOutput(1, 28'h099, 8, "w8.99");
        applyStimulus(1, 20'd100);  checkOutput(1, 28'h100, 8, "w8.100");
        applyStimulus(2, 20'd2048); checkOutput(2, 28'h2048, 12, "w12.2048");
        applyStimulus(3, 20'd0);    checkOutput(3, 28'h0, 20, "w20.0");

        // Largest operand at the widest configuration, then the busy window length.
        applyStimulus(3, 20'd1048575);
        checkOutput(3, 28'h1048575, 20, "w20.max");
        applyStimulus(3, 20'd1048575);
        n = 0;
        while (inReady[3] !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("w20.readyLowCycles", 28'(n), 28'd21);
        repeat (2) @(negedge clk);

        // A request during a conversion is dropped.
        pc = pulseCnt[1];
        applyStimulus(1, 20'd200);
        @(negedge clk);
        @(negedge clk);
        inValid[1] = 1'b1;
        binCode[1] = 20'd77;
        @(negedge clk);
        inValid[1] = 1'b0;
        checkOutput(1, 28'h200, 5, "w8.200busyReq");
        repeat (20) @(negedge clk);
        check("w8.singlePulse", 28'(pulseCnt[1] - pc), 28'd1);

        // Reset in the middle of a conversion aborts it.
        applyStimulus(1, 20'd255);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("w8.abort.readyNow", 28'(inReady[1]), 28'd1);
        check("w8.abort.validNow", 28'(outValid[1]), 28'd0);
        pc = pulseCnt[1];
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("w8.abort.noPulse", 28'(pulseCnt[1] - pc), 28'd0);
        applyStimulus(1, 20'd128);
        checkOutput(1, 28'h128, 8, "w8.128afterReset");

        // Back-to-back with in_valid held high; operand changes right after each accept.
        ops[0] = 20'd4095;
        ops[1] = 20'd1000;
        ops[2] = 20'd1;
        startIdx = pulses.size();
        @(negedge clk);
        inValid[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            binCode[2] = ops[k];
            waitReady(2, "w12.b2b");
            @(negedge clk);
        end
        inValid[2] = 1'b0;
        repeat (20) @(negedge clk);
        found = 0;
        for (int j = startIdx; j < pulses.size(); j++) begin
            if (pulses[j].inst == 2) begin
                if (found < 3) begin
                    pcyc[found] = pulses[j].cyc;
                    pbcd[found] = pulses[j].bcd;
                end
                found++;
            end
        end
        check("w12.b2b.pulseCount", 28'(found), 28'd3);
        if (found >= 3) begin
            check("w12.b2b.first", pbcd[0], 28'h4095);
            check("w12.b2b.second", pbcd[1], 28'h1000);
            check("w12.b2b.third", pbcd[2], 28'h0001);
            check("w12.b2b.gap1", 28'(pcyc[1] - pcyc[0]), 28'd14);
            check("w12.b2b.gap2", 28'(pcyc[2] - pcyc[1]), 28'd14);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
